// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel output path.
// Colour width, batch width and raster geometry live here so every block agrees on them.
package pixel_pkg;

  localparam int RGB_SIZE    = 24;
  localparam int NUM_ENGINES = 12;
  localparam int X_SIZE      = 640;
  localparam int Y_SIZE      = 480;

  typedef logic [RGB_SIZE-1:0]  rgb_t;
  typedef rgb_t [NUM_ENGINES-1:0] rgb_batch_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_DRAIN = 1'b1
  } ser_state_e;

  // Counter width that stays legal for degenerate sizes of 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x/y counters advanced once per pixel transfer,
// with start-of-frame, end-of-line and end-of-frame decodes.
module raster_counter
  import pixel_pkg::*;
#(
  parameter int X_SIZE = pixel_pkg::X_SIZE,
  parameter int Y_SIZE = pixel_pkg::Y_SIZE,
  localparam int XW = cw(X_SIZE),
  localparam int YW = cw(Y_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          frame_end_o
);

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign sof_o       = (x_q == '0) && (y_q == '0);
  assign eol_o       = (x_q == X_LAST);
  assign frame_end_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/pixel_serializer.sv
// Takes a batch of NUM_ENGINES colours per handshake and streams them one pixel
// per clock in raster order, tagging start-of-frame and end-of-line.
module pixel_serializer
  import pixel_pkg::*;
#(
  parameter int RGB_SIZE    = pixel_pkg::RGB_SIZE,
  parameter int NUM_ENGINES = pixel_pkg::NUM_ENGINES,
  parameter int X_SIZE      = pixel_pkg::X_SIZE,
  parameter int Y_SIZE      = pixel_pkg::Y_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_ENGINES-1:0][RGB_SIZE-1:0] in_rgb,
  output logic [RGB_SIZE-1:0]                  out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_sof,
  output logic                                 out_eol
);

  localparam int IW = cw(NUM_ENGINES);
  localparam int XW = cw(X_SIZE);
  localparam int YW = cw(Y_SIZE);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ENGINES - 1);

  ser_state_e                           state_q;
  logic [NUM_ENGINES-1:0][RGB_SIZE-1:0] buf_q;
  logic [IW-1:0]                        idx_q;

  logic          full, xfer, last_slot, accept, frame_end;
  logic [XW-1:0] unused_x;
  logic [YW-1:0] unused_y;

  assign full      = (state_q == S_DRAIN);
  assign xfer      = full && out_ready;
  // A frame ends mid-batch when the frame size is not a multiple of the batch.
  assign last_slot = (idx_q == IDX_LAST) || frame_end;
  assign in_ready  = !full || (xfer && last_slot);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            buf_q   <= in_rgb;
            idx_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            if (last_slot) begin
              idx_q <= '0;
              if (in_valid) begin
                buf_q <= in_rgb;
              end else begin
                state_q <= S_EMPTY;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  raster_counter #(
    .X_SIZE(X_SIZE),
    .Y_SIZE(Y_SIZE)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance_i  (xfer),
    .x_o        (unused_x),
    .y_o        (unused_y),
    .sof_o      (out_sof),
    .eol_o      (out_eol),
    .frame_end_o(frame_end)
  );

  assign out_valid = full;
  assign out_data  = buf_q[idx_q];

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer: directed batches on a 6x3 raster with 8-pixel
// batches; a scoreboard monitor checks every presented pixel.
module tb_pixel_serializer;

  localparam int NE    = 8;
  localparam int XS    = 6;
  localparam int YS    = 3;
  localparam int RW    = 24;
  localparam int FRAME = XS * YS;

  typedef logic [NE-1:0][RW-1:0] batch_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          rand_mode = 1'b0;
  batch_t        in_rgb = '0;
  logic          in_ready, out_valid, out_sof, out_eol;
  logic [RW-1:0] out_data;

  int vecs = 0;
  int errs = 0;
  int bubbles = 0;
  batch_t bq[$];

  always #5 clk = ~clk;

  pixel_serializer #(
    .RGB_SIZE(RW), .NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic batch_t mk(input int base);
    batch_t b;
    for (int i = 0; i < NE; i++) b[i] = RW'(base + i);
    return b;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor: pos is the model's pixel index within the frame.
  batch_t        cur;
  logic          have_cur = 1'b0;
  int            slot = 0;
  int            pos = 0;
  logic          stalled = 1'b0;
  logic [RW+1:0] st_snap;
  logic          last;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bq.delete();
      have_cur = 1'b0;
      slot     = 0;
      pos      = 0;
      stalled  = 1'b0;
    end else if (!out_valid) begin
      bubbles++;
      chk1("in_ready_idle", in_ready, 1'b1);
      chk1("valid_vs_model", out_valid, have_cur);
      chk1("stall_dropped", stalled, 1'b0);
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_hold", 32'({out_data, out_sof, out_eol}), 32'(st_snap));
      stalled = 1'b0;
      if (!have_cur) begin
        if (bq.size() == 0) begin
          chk1("unexpected_pixel", out_valid, 1'b0);
        end else begin
          cur      = bq.pop_front();
          have_cur = 1'b1;
          slot     = 0;
        end
      end
      if (have_cur) begin
        chk("data", 32'(out_data), 32'(cur[slot]));
        chk1("sof", out_sof, pos == 0);
        chk1("eol", out_eol, (pos % XS) == XS - 1);
        last = (slot == NE - 1) || (pos == FRAME - 1);
        if (out_ready) begin
          chk1("in_ready_xfer", in_ready, last);
          if (last) have_cur = 1'b0;
          else slot++;
          pos = (pos == FRAME - 1) ? 0 : pos + 1;
        end else begin
          chk1("in_ready_stall", in_ready, 1'b0);
          stalled = 1'b1;
          st_snap = {out_data, out_sof, out_eol};
        end
      end
    end
  end

  // Returns on the negedge at which the handshake is seen; in_valid stays high.
  task automatic send_batch(input batch_t b);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_rgb   = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        bq.push_back(b);
        return;
      end
      n++;
      if (n > 200) begin
        chk1("accept_timeout", in_ready, 1'b1);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drop();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!out_valid && bq.size() == 0 && !have_cur) return;
    end
    chk1("drain_timeout", out_valid, 1'b0);
  endtask

  int b0, gin, olow, cnt;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_sof", out_sof, 1'b1);
    chk1("rst_out_eol", out_eol, 1'b0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    #2 rst_n = 1'b1;

    // Single batch 1..8: valid rises the cycle after accept
    send_batch(mk(1));
    chk1("t1_valid_at_accept", out_valid, 1'b0);
    drop();
    @(negedge clk);
    chk1("t1_valid_after", out_valid, 1'b1);
    chk("t1_first_data", 32'(out_data), 32'h1);
    wait_drain();
    chk1("t1_drained", out_valid, 1'b0);

    // Gapless stream from pos 8; second batch truncated at frame end
    send_batch(mk('h100));
    fork begin @(posedge clk); b0 = bubbles; end join_none
    send_batch(mk('h200));
    send_batch(mk('h300));
    send_batch(mk('h400));
    chk("t2_bubbles", 32'(bubbles - b0), 32'h0);
    drop();
    wait_drain();

    // Truncated batch at pos 16, then a 3-cycle in_valid gap
    send_batch(mk('h500));
    drop();
    gin = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && in_ready) begin gin = 1; break; end
    end
    chk("t3_last_seen", 32'(gin), 32'h1);
    olow = 0;
    repeat (2) begin
      @(negedge clk);
      gin++;
      if (!out_valid) olow++;
    end
    send_batch(mk('h600));
    if (!out_valid) olow++;
    chk("t3_gap_len", 32'(olow), 32'(gin));
    drop();
    @(negedge clk);
    chk1("t3_new_frame_sof", out_sof, 1'b1);
    chk("t3_new_frame_data", 32'(out_data), 32'h600);
    wait_drain();

    // Random backpressure
    rand_mode = 1'b1;
    send_batch(mk('h700));
    send_batch(mk('h800));
    send_batch(mk('h900));
    drop();
    wait_drain();
    rand_mode = 1'b0;

    // Reset after pixel 5 of a batch that starts mid-frame
    send_batch(mk('hB00));
    drop();
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 5; n++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
    end
    chk("t5_pixels_before_rst", 32'(cnt), 32'd5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk1("t5_rst_valid", out_valid, 1'b0);
    chk1("t5_rst_in_ready", in_ready, 1'b1);
    chk1("t5_rst_sof", out_sof, 1'b1);
    chk("t5_rst_data", 32'(out_data), 32'h0);
    #1 rst_n = 1'b1;
    send_batch(mk('hC00));
    drop();
    @(negedge clk);
    chk1("t5_after_rst_sof", out_sof, 1'b1);
    chk("t5_after_rst_data", 32'(out_data), 32'hC00);
    wait_drain();

    chk("queue_empty", 32'(bq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
